// File: rtl/ball_motion_if.sv
// Ball-motion bus: frame tick, pause and paddle rows in; ball position,
// point pulses and serve flag out.
//   master : game/display side (drives tick, pause, paddle rows)
//   slave  : ball_motion engine (drives ball position, scores, serving)
interface ball_motion_if #(
  parameter int X_POS_W = 10,
  parameter int Y_POS_W = 10
);
  logic               new_frame_i;
  logic               pause_i;
  logic [Y_POS_W-1:0] left_paddle_y_i;
  logic [Y_POS_W-1:0] right_paddle_y_i;
  logic [X_POS_W-1:0] ball_x_o;
  logic [Y_POS_W-1:0] ball_y_o;
  logic               score_left_o;
  logic               score_right_o;
  logic               serving_o;

  modport master (
    output new_frame_i, pause_i, left_paddle_y_i, right_paddle_y_i,
    input  ball_x_o, ball_y_o, score_left_o, score_right_o, serving_o
  );

  modport slave (
    input  new_frame_i, pause_i, left_paddle_y_i, right_paddle_y_i,
    output ball_x_o, ball_y_o, score_left_o, score_right_o, serving_o
  );
endinterface

// File: rtl/ball_motion.sv
// Pong ball engine. Once per unpaused frame tick the ball either rests at
// the centre (SERVE), moves diagonally with wall/paddle bounces (PLAY), or
// is recentred after a point (SCORED).
// Ports:
//   clk_i   : clock, posedge
//   rst_ni  : synchronous active-low reset
//   bus     : ball_motion_if.slave (tick, pause, paddle rows in;
//             ball_x/ball_y, score pulses, serving out, all registered)
module ball_motion #(
  parameter int SCREEN_H_RES   = 640,
  parameter int SCREEN_V_RES   = 480,
  parameter int X_POS_W        = 10,
  parameter int Y_POS_W        = 10,
  parameter int BALL_SIDE      = 8,
  parameter int PADDLE_WIDTH   = 8,
  parameter int PADDLE_HEIGHT  = 64,
  parameter int LEFT_PADDLE_X  = 16,
  parameter int RIGHT_PADDLE_X = 616,
  parameter int BALL_SPEED     = 2,
  parameter int SERVE_FRAMES   = 60
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  ball_motion_if.slave  bus
);

  localparam int CX     = (SCREEN_H_RES - BALL_SIDE) / 2;
  localparam int CY     = (SCREEN_V_RES - BALL_SIDE) / 2;
  localparam int X_MAX  = SCREEN_H_RES - BALL_SIDE;
  localparam int Y_MAX  = SCREEN_V_RES - BALL_SIDE;
  localparam int L_EDGE = LEFT_PADDLE_X + PADDLE_WIDTH;  // left paddle's right face
  localparam int CNT_W  = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

  typedef enum logic [1:0] {SERVE, PLAY, SCORED} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [X_POS_W-1:0] ball_x_q;
  logic [Y_POS_W-1:0] ball_y_q;
  logic               dir_right_q, dir_down_q;
  logic               score_l_q, score_r_q, serving_q;

  logic tick;
  assign tick = bus.new_frame_i & ~bus.pause_i;

  // Next-position math is done in signed int so stepping past 0 or past the
  // far edge shows up as a negative / oversized value instead of wrapping.
  int   x, y, nx, ny, lpy, rpy, x_d, y_d;
  logic ovl_l, ovl_r, hit_l, hit_r, miss_l, miss_r;
  logic dir_right_d, dir_down_d;

  always_comb begin
    x   = int'(ball_x_q);
    y   = int'(ball_y_q);
    lpy = int'(bus.left_paddle_y_i);
    rpy = int'(bus.right_paddle_y_i);
    nx  = dir_right_q ? x + BALL_SPEED : x - BALL_SPEED;
    ny  = dir_down_q  ? y + BALL_SPEED : y - BALL_SPEED;

    // Vertical axis: clamp onto the wall and reflect; exact landing stays.
    y_d        = ny;
    dir_down_d = dir_down_q;
    if (dir_down_q && ny > Y_MAX) begin
      y_d        = Y_MAX;
      dir_down_d = 1'b0;
    end else if (!dir_down_q && ny < 0) begin
      y_d        = 0;
      dir_down_d = 1'b1;
    end

    // Horizontal axis: a hit needs the ball to cross the paddle face this
    // tick (was clear of it, now past it) while overlapping it vertically.
    ovl_l  = (ny + BALL_SIDE > lpy) && (ny < lpy + PADDLE_HEIGHT);
    ovl_r  = (ny + BALL_SIDE > rpy) && (ny < rpy + PADDLE_HEIGHT);
    hit_l  = !dir_right_q && (x >= L_EDGE) && (nx < L_EDGE) && ovl_l;
    hit_r  = dir_right_q && (x + BALL_SIDE <= RIGHT_PADDLE_X) &&
             (nx + BALL_SIDE > RIGHT_PADDLE_X) && ovl_r;
    miss_l = !dir_right_q && !hit_l && (nx < 0);
    miss_r = dir_right_q && !hit_r && (nx > X_MAX);

    x_d         = nx;
    dir_right_d = dir_right_q;
    if (hit_l) begin
      x_d         = L_EDGE;
      dir_right_d = 1'b1;
    end else if (hit_r) begin
      x_d         = RIGHT_PADDLE_X - BALL_SIDE;
      dir_right_d = 1'b0;
    end else if (miss_l) begin
      x_d = 0;
    end else if (miss_r) begin
      x_d = X_MAX;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= SERVE;
      cnt_q       <= '0;
      ball_x_q    <= X_POS_W'(CX);
      ball_y_q    <= Y_POS_W'(CY);
      dir_right_q <= 1'b1;
      dir_down_q  <= 1'b1;
      score_l_q   <= 1'b0;
      score_r_q   <= 1'b0;
      serving_q   <= 1'b1;
    end else begin
      // Point pulses last exactly one cycle regardless of tick spacing.
      score_l_q <= 1'b0;
      score_r_q <= 1'b0;
      if (tick) begin
        case (state_q)
          SERVE: begin
            if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
              state_q   <= PLAY;
              cnt_q     <= '0;
              serving_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          PLAY: begin
            ball_x_q    <= X_POS_W'(x_d);
            ball_y_q    <= Y_POS_W'(y_d);
            dir_right_q <= dir_right_d;
            dir_down_q  <= dir_down_d;
            if (miss_l || miss_r) begin
              score_r_q <= miss_l;
              score_l_q <= miss_r;
              state_q   <= SCORED;
            end
          end
          SCORED: begin
            // dir_x is left untouched: on a miss it still points at the side
            // that conceded, which is where the next serve goes.
            ball_x_q  <= X_POS_W'(CX);
            ball_y_q  <= Y_POS_W'(CY);
            cnt_q     <= '0;
            state_q   <= SERVE;
            serving_q <= 1'b1;
          end
          default: state_q <= SERVE;
        endcase
      end
    end
  end

  assign bus.ball_x_o      = ball_x_q;
  assign bus.ball_y_o      = ball_y_q;
  assign bus.score_left_o  = score_l_q;
  assign bus.score_right_o = score_r_q;
  assign bus.serving_o     = serving_q;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion. u1 uses default geometry and walks one long
// rally (serve, bottom wall, right paddle, top wall, left paddle). u2 uses a
// tiny 40x24 court so a corner bounce, a left miss and a reset that collides
// with a miss are reached in a handful of ticks.
module tb_ball_motion;
  logic clk = 1'b0;
  logic rst1_n, rst2_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ball_motion_if #(.X_POS_W(10), .Y_POS_W(10)) bus1 ();
  ball_motion_if #(.X_POS_W(10), .Y_POS_W(10)) bus2 ();

  ball_motion u1 (.clk_i(clk), .rst_ni(rst1_n), .bus(bus1));

  ball_motion #(
    .SCREEN_H_RES(40), .SCREEN_V_RES(24), .X_POS_W(10), .Y_POS_W(10),
    .BALL_SIDE(8), .PADDLE_WIDTH(4), .PADDLE_HEIGHT(64),
    .LEFT_PADDLE_X(4), .RIGHT_PADDLE_X(32), .BALL_SPEED(2), .SERVE_FRAMES(1)
  ) u2 (.clk_i(clk), .rst_ni(rst2_n), .bus(bus2));

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input bit u, input string tag, input int x, input int y,
                        input int srv, input int sl, input int sr);
    if (!u) begin
      chk({tag, ".x"}, int'(bus1.ball_x_o), x);
      chk({tag, ".y"}, int'(bus1.ball_y_o), y);
      chk({tag, ".srv"}, int'(bus1.serving_o), srv);
      chk({tag, ".scl"}, int'(bus1.score_left_o), sl);
      chk({tag, ".scr"}, int'(bus1.score_right_o), sr);
    end else begin
      chk({tag, ".x"}, int'(bus2.ball_x_o), x);
      chk({tag, ".y"}, int'(bus2.ball_y_o), y);
      chk({tag, ".srv"}, int'(bus2.serving_o), srv);
      chk({tag, ".scl"}, int'(bus2.score_left_o), sl);
      chk({tag, ".scr"}, int'(bus2.score_right_o), sr);
    end
  endtask

  // n consecutive tick cycles; entered and left on a negedge, so outputs
  // are sampled one cycle after the last tick.
  task automatic run(input bit u, input int n);
    if (!u) bus1.new_frame_i = 1'b1; else bus2.new_frame_i = 1'b1;
    repeat (n) @(negedge clk);
    bus1.new_frame_i = 1'b0;
    bus2.new_frame_i = 1'b0;
  endtask

  initial begin
    rst1_n = 1'b0; rst2_n = 1'b0;
    bus1.new_frame_i = 1'b0; bus1.pause_i = 1'b0;
    bus1.left_paddle_y_i = 10'd150; bus1.right_paddle_y_i = 10'd400;
    bus2.new_frame_i = 1'b0; bus2.pause_i = 1'b0;
    bus2.left_paddle_y_i = 10'd100; bus2.right_paddle_y_i = 10'd0;
    repeat (3) @(negedge clk);
    rst1_n = 1'b1; rst2_n = 1'b1;

    // ---- u1: default court ----
    chk_st(0, "u1_reset", 316, 236, 1, 0, 0);
    run(0, 59);  chk_st(0, "u1_serve59", 316, 236, 1, 0, 0);
    run(0, 1);   chk_st(0, "u1_serve60", 316, 236, 0, 0, 0);
    bus1.pause_i = 1'b1;
    run(0, 1);   chk_st(0, "u1_pause", 316, 236, 0, 0, 0);
    bus1.pause_i = 1'b0;
    run(0, 1);   chk_st(0, "u1_k1", 318, 238, 0, 0, 0);
    run(0, 117); chk_st(0, "u1_k118_land472", 552, 472, 0, 0, 0);
    run(0, 1);   chk_st(0, "u1_k119_bottom", 554, 472, 0, 0, 0);
    run(0, 1);   chk_st(0, "u1_k120_up", 556, 470, 0, 0, 0);
    run(0, 26);  chk_st(0, "u1_k146", 608, 418, 0, 0, 0);
    run(0, 1);   chk_st(0, "u1_k147_rpaddle", 608, 416, 0, 0, 0);
    run(0, 1);   chk_st(0, "u1_k148_left", 606, 414, 0, 0, 0);
    run(0, 207); chk_st(0, "u1_k355_land0", 192, 0, 0, 0, 0);
    run(0, 1);   chk_st(0, "u1_k356_top", 190, 0, 0, 0, 0);
    run(0, 1);   chk_st(0, "u1_k357_down", 188, 2, 0, 0, 0);
    run(0, 82);  chk_st(0, "u1_k439", 24, 166, 0, 0, 0);
    run(0, 1);   chk_st(0, "u1_k440_lpaddle", 24, 168, 0, 0, 0);
    run(0, 1);   chk_st(0, "u1_k441_right", 26, 170, 0, 0, 0);

    // ---- u2: small court, pass A ends with reset colliding with a miss ----
    chk_st(1, "u2_reset", 16, 8, 1, 0, 0);
    run(1, 1);   chk_st(1, "u2_serve", 16, 8, 0, 0, 0);
    run(1, 4);   chk_st(1, "u2_k4", 24, 16, 0, 0, 0);
    run(1, 1);   chk_st(1, "u2_k5_corner", 24, 16, 0, 0, 0);
    run(1, 1);   chk_st(1, "u2_k6", 22, 14, 0, 0, 0);
    run(1, 11);  chk_st(1, "u2_k17", 0, 6, 0, 0, 0);
    rst2_n = 1'b0;
    run(1, 1);
    rst2_n = 1'b1;
    chk_st(1, "u2_rst_over_miss", 16, 8, 1, 0, 0);

    // ---- u2 pass B: the miss goes through ----
    run(1, 1);   chk_st(1, "u2b_serve", 16, 8, 0, 0, 0);
    run(1, 16);  chk_st(1, "u2b_k16", 2, 4, 0, 0, 0);
    run(1, 1);   chk_st(1, "u2b_k17", 0, 6, 0, 0, 0);
    run(1, 1);   chk_st(1, "u2b_miss", 0, 8, 0, 0, 1);
    @(negedge clk);
    chk_st(1, "u2b_pulse_end", 0, 8, 0, 0, 0);
    run(1, 1);   chk_st(1, "u2b_recentre", 16, 8, 1, 0, 0);
    run(1, 1);   chk_st(1, "u2b_serve2", 16, 8, 0, 0, 0);
    run(1, 1);   chk_st(1, "u2b_serve_left", 14, 10, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
